disp_scheduler: RTL and testbench

DISP_SCHEDULER -- requirements
Module: disp_scheduler

---
 rtl/disp_scheduler.sv | 136 +++++++++++++
 tb/tb_disp_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scheduler.sv
// Display scheduler: picks the digit word for the multiplexer from base content
// (with per-digit blinking) or an overlay that is held for a while after the
// request drops.
module disp_scheduler #(
  parameter int          HOLD_MS       = 2000,
  parameter int          BLINK_HALF_MS = 250,
  parameter logic [3:0]  BLANK_CODE    = 4'hF
) (
  input  logic        clk1KHz,
  input  logic        reset,
  input  logic [31:0] base_data,
  input  logic        ovl_req,
  input  logic [31:0] ovl_data,
  input  logic [7:0]  blink_en,
  output logic [31:0] all_data,
  output logic        ovl_active
);

  typedef enum logic [1:0] {
    ST_BASE,
    ST_OVERLAY,
    ST_HOLD
  } state_t;

  localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_MS - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF_MS - 1);

  state_t      state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;        // 1 = blinking digits hidden
  logic [31:0] ovl_latch_q, ovl_latch_d;
  logic [31:0] all_data_q, all_data_d;
  logic        ovl_active_q, ovl_active_d;

  // Replace every blink-enabled digit with the blank code while hidden.
  function automatic logic [31:0] apply_blink(input logic [31:0] word,
                                              input logic [7:0]  mask,
                                              input logic        hidden);
    logic [31:0] res;
    res = word;
    for (int i = 0; i < 8; i++) begin
      if (hidden && mask[i]) res[i*4 +: 4] = BLANK_CODE;
    end
    return res;
  endfunction

  // Next-state logic for the overlay FSM and its hold counter.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_BASE: begin
        if (ovl_req) state_d = ST_OVERLAY;
      end
      ST_OVERLAY: begin
        if (!ovl_req) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (ovl_req) begin
          state_d = ST_OVERLAY;
        end else if (hold_cnt_q == 16'd0) begin
          state_d = ST_BASE;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: state_d = ST_BASE;
    endcase
  end

  // Blink half-period counter; parked at the start of a visible phase while no
  // digit blinks so a fresh mask always begins with a full visible period.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (blink_en == 8'h00) begin
      blink_cnt_d = 16'd0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = 16'd0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 16'd1;
    end
  end

  // Output word follows the state being entered on this edge, so the overlay
  // shows one edge after the request and the held word lasts exactly the hold
  // time; the latch only tracks ovl_data while it is actually being displayed.
  always_comb begin
    all_data_d   = apply_blink(base_data, blink_en, phase_q);
    ovl_active_d = 1'b0;
    ovl_latch_d  = ovl_latch_q;
    case (state_d)
      ST_OVERLAY: begin
        all_data_d   = ovl_data;
        ovl_active_d = 1'b1;
        ovl_latch_d  = ovl_data;
      end
      ST_HOLD: begin
        all_data_d   = ovl_latch_q;
        ovl_active_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk1KHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BASE;
      hold_cnt_q   <= 16'd0;
      blink_cnt_q  <= 16'd0;
      phase_q      <= 1'b0;
      ovl_latch_q  <= 32'h0;
      all_data_q   <= 32'h0;
      ovl_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      ovl_latch_q  <= ovl_latch_d;
      all_data_q   <= all_data_d;
      ovl_active_q <= ovl_active_d;
    end
  end

  assign all_data   = all_data_q;
  assign ovl_active = ovl_active_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler with a short hold and blink period.
module tb_disp_scheduler;

  localparam int HOLD_MS       = 4;
  localparam int BLINK_HALF_MS = 3;

  logic        clk1KHz = 1'b0;
  logic        reset;
  logic [31:0] base_data;
  logic        ovl_req;
  logic [31:0] ovl_data;
  logic [7:0]  blink_en;
  logic [31:0] all_data;
  logic        ovl_active;

  int n_checks = 0;
  int n_pass   = 0;

  // reference state
  int          m_mode;     // 0 base, 1 overlay, 2 hold
  int          m_remain;
  logic [31:0] m_latch;
  int          m_bc;
  logic        m_hidden;

  logic [32:0] exp_q[$];

  disp_scheduler #(
    .HOLD_MS(HOLD_MS),
    .BLINK_HALF_MS(BLINK_HALF_MS),
    .BLANK_CODE(4'hF)
  ) dut (
    .clk1KHz(clk1KHz),
    .reset(reset),
    .base_data(base_data),
    .ovl_req(ovl_req),
    .ovl_data(ovl_data),
    .blink_en(blink_en),
    .all_data(all_data),
    .ovl_active(ovl_active)
  );

  always #5 clk1KHz = ~clk1KHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_remain = 0;
    m_latch  = 32'h0;
    m_bc     = 0;
    m_hidden = 1'b0;
    exp_q.delete();
  endtask

  // What the display should show after the coming edge, given current inputs.
  task automatic model_edge(output logic [32:0] e);
    logic [31:0] shown_base;
    logic [31:0] w;
    logic        a;
    shown_base = base_data;
    if (m_hidden)
      for (int i = 0; i < 8; i++)
        if (blink_en[i]) shown_base[i*4 +: 4] = 4'hF;
    if (blink_en == 8'h00) begin
      m_bc     = 0;
      m_hidden = 1'b0;
    end else begin
      m_bc++;
      if (m_bc == BLINK_HALF_MS) begin
        m_bc     = 0;
        m_hidden = ~m_hidden;
      end
    end
    if (ovl_req) begin
      m_mode  = 1;
      m_latch = ovl_data;
      w = ovl_data;
      a = 1'b1;
    end else if (m_mode == 1) begin
      m_mode   = 2;
      m_remain = HOLD_MS - 1;
      w = m_latch;
      a = 1'b1;
    end else if (m_mode == 2 && m_remain > 0) begin
      m_remain--;
      w = m_latch;
      a = 1'b1;
    end else begin
      m_mode = 0;
      w = shown_base;
      a = 1'b0;
    end
    e = {a, w};
  endtask

  // One clock: predict, advance, then compare against the oldest prediction.
  task automatic step();
    logic [32:0] e;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk1KHz);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sb_data", all_data, e[31:0]);
      check("sb_active", {31'd0, ovl_active}, {31'd0, e[32]});
    end
  endtask

  initial begin
    reset     = 1'b1;
    base_data = 32'h12345678;
    ovl_req   = 1'b0;
    ovl_data  = 32'h0;
    blink_en  = 8'h00;
    model_reset();
    @(posedge clk1KHz);
    #1;
    check("rst_data", all_data, 32'h0);
    check("rst_active", {31'd0, ovl_active}, 32'd0);

    // base word from the first edge after release
    reset = 1'b0;
    step();
    check("base_first", all_data, 32'h12345678);
    check("base_inactive", {31'd0, ovl_active}, 32'd0);
    step();

    // overlay for two cycles, then drop with new data that must not show
    ovl_req  = 1'b1;
    ovl_data = 32'hAAAA0000;
    step();
    check("ovl_shown", all_data, 32'hAAAA0000);
    check("ovl_active", {31'd0, ovl_active}, 32'd1);
    step();
    ovl_req  = 1'b0;
    ovl_data = 32'h00005555;
    for (int i = 0; i < HOLD_MS; i++) begin
      step();
      check("hold_word", all_data, 32'hAAAA0000);
      check("hold_active", {31'd0, ovl_active}, 32'd1);
    end
    step();
    check("hold_end_base", all_data, 32'h12345678);
    check("hold_end_inactive", {31'd0, ovl_active}, 32'd0);

    // re-request during the second hold cycle: no base word in between
    ovl_req  = 1'b1;
    ovl_data = 32'hBEEF0001;
    step();
    step();
    ovl_req  = 1'b0;
    ovl_data = 32'h0BAD0BAD;
    step();
    step();
    ovl_req  = 1'b1;
    ovl_data = 32'hBEEF0002;
    step();
    check("rereq_word", all_data, 32'hBEEF0002);
    ovl_req  = 1'b0;
    ovl_data = 32'h0BAD0BAD;
    for (int i = 0; i < HOLD_MS; i++) begin
      step();
      check("rehold_word", all_data, 32'hBEEF0002);
    end
    step();
    check("rehold_base", all_data, 32'h12345678);

    // blinking digits 1:0: three visible, three hidden, repeating
    blink_en = 8'h03;
    for (int i = 0; i < 12; i++) begin
      step();
      check("blink_word", all_data, ((i / 3) % 2 == 0) ? 32'h12345678 : 32'h123456FF);
    end

    // overlay is never blanked
    ovl_req  = 1'b1;
    ovl_data = 32'hCAFEBEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ovl_noblink", all_data, 32'hCAFEBEEF);
    end
    ovl_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    blink_en = 8'h00;
    step();

    // reset in the middle of a hold
    ovl_req  = 1'b1;
    ovl_data = 32'h77778888;
    step();
    step();
    ovl_req = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_data", all_data, 32'h0);
    check("async_rst_active", {31'd0, ovl_active}, 32'd0);
    @(posedge clk1KHz);
    #1;
    check("held_rst_data", all_data, 32'h0);
    reset = 1'b0;
    model_reset();
    step();
    check("post_rst_base", all_data, 32'h12345678);
    check("post_rst_inactive", {31'd0, ovl_active}, 32'd0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) ovl_req = ~ovl_req;
      ovl_data = $urandom();
      if ($urandom_range(0, 9) == 0) base_data = $urandom();
      if ($urandom_range(0, 19) == 0)
        blink_en = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom());
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
